// File: rtl/noc_eject_sink_pkg.sv
// Shared definitions for the NoC ejection sink: flit field positions,
// error bit positions, per-VC packet state and the credit delay clamp.
package noc_eject_sink_pkg;

  // Default geometry of the flit/staging word and the sink
  localparam int FLIT_W_DEF = 12;
  localparam int VC_W_DEF   = 2;
  localparam int ID_W_DEF   = 4;
  localparam int MAX_CD_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Flit field positions: [0] full, [2:1] vc, [3] head, [4] tail, [8:5] dst, [11:9] reserved
  localparam int FULL_BIT = 0;
  localparam int VC_LSB   = 1;
  localparam int HEAD_BIT = 3;
  localparam int TAIL_BIT = 4;
  localparam int DST_LSB  = 5;
  localparam int RSV_LSB  = 9;

  // Sticky error bit positions
  localparam int ERR_DUP_HEAD = 0;
  localparam int ERR_ORPHAN   = 1;
  localparam int ERR_DST      = 2;

  // Per-VC reassembly state
  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_OPEN = 1'b1
  } vc_state_e;

  // Effective credit delay: zero means one cycle, large values saturate at max_cd
  function automatic logic [3:0] clamp_delay(input logic [3:0] cd, input logic [3:0] max_cd);
    logic [3:0] res;
    if (cd == 4'd0) begin
      res = 4'd1;
    end else if (cd > max_cd) begin
      res = max_cd;
    end else begin
      res = cd;
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_eject_sink_credit_delay_line.sv
// Credit delay line: a DEPTH-stage shift register of {valid, vc} with a
// runtime tap (1..DEPTH) and a registered output. A pulse entering at edge t
// appears on the output after edge t + tap. clr flushes every stage.
module noc_eject_sink_credit_delay_line #(
  parameter int DEPTH = 8,
  parameter int VC_W  = 2,
  parameter int TAP_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [VC_W-1:0]  in_vc,
  input  logic [TAP_W-1:0] tap,
  output logic             out_valid,
  output logic [VC_W-1:0]  out_vc
);

  logic [DEPTH-1:0] stg_valid_r;
  logic [VC_W-1:0]  stg_vc_r [DEPTH];
  logic             tap_valid_s;
  logic [VC_W-1:0]  tap_vc_s;
  logic             out_valid_r;
  logic [VC_W-1:0]  out_vc_r;

  // Select the stage addressed by tap; an out-of-range tap selects nothing
  always_comb begin
    tap_valid_s = 1'b0;
    tap_vc_s    = {VC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      tap_valid_s = tap_valid_s | ((tap == TAP_W'(i + 1)) & stg_valid_r[i]);
      tap_vc_s    = tap_vc_s | ({VC_W{tap == TAP_W'(i + 1)}} & stg_vc_r[i]);
    end
  end

  // Shift credits along the line and register the tapped stage
  always_ff @(posedge clk) begin
    if (clr) begin
      stg_valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        stg_vc_r[i] <= {VC_W{1'b0}};
      end
      out_valid_r <= 1'b0;
      out_vc_r    <= {VC_W{1'b0}};
    end else begin
      stg_valid_r <= {stg_valid_r[DEPTH-2:0], in_valid};
      stg_vc_r[0] <= in_valid ? in_vc : {VC_W{1'b0}};
      for (int i = 1; i < DEPTH; i++) begin
        stg_vc_r[i] <= stg_vc_r[i-1];
      end
      out_valid_r <= tap_valid_s;
      out_vc_r    <= tap_vc_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_vc    = out_vc_r;

endmodule

// File: rtl/noc_eject_sink.sv
// NoC ejection sink: consumes flits from a router's local output, tracks
// per-VC packet framing, checks destination, counts flits/packets and
// returns one credit per accepted flit after the configured delay.
module noc_eject_sink
  import noc_eject_sink_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int VC_W   = VC_W_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int MAX_CD = MAX_CD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic [3:0]        cfg_credit_delay,
  input  logic [CNT_W-1:0]  cfg_expected,
  input  logic [FLIT_W-1:0] in_flit,
  output logic [FLIT_W-1:0] cr_out,
  output logic [CNT_W-1:0]  flit_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [2:0]        err,
  output logic              done
);

  localparam int MAX_VC = 1 << VC_W;

  // Saturating increment so counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic              flit_valid_s;
  logic              flit_head_s;
  logic              flit_tail_s;
  logic [VC_W-1:0]   flit_vc_s;
  logic [ID_W-1:0]   flit_dst_s;
  logic              unused_s;

  logic [ID_W-1:0]   cfg_id_r;
  logic [3:0]        d_eff_r;
  logic [CNT_W-1:0]  cfg_expected_r;

  vc_state_e         vc_state_r [MAX_VC];
  logic [CNT_W-1:0]  flit_count_r;
  logic [CNT_W-1:0]  pkt_count_r;
  logic [2:0]        err_r;
  logic              done_r;
  logic              any_open_s;
  logic              clear_s;

  logic              cr_valid_s;
  logic [VC_W-1:0]   cr_vc_s;

  assign flit_valid_s = in_flit[FULL_BIT];
  assign flit_vc_s    = in_flit[VC_LSB +: VC_W];
  assign flit_head_s  = in_flit[HEAD_BIT];
  assign flit_tail_s  = in_flit[TAIL_BIT];
  assign flit_dst_s   = in_flit[DST_LSB +: ID_W];
  assign unused_s     = ^in_flit[FLIT_W-1:RSV_LSB];

  assign clear_s = rst | cfg_load;

  // Configuration registers: defaults on rst, captured on cfg_load
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_id_r       <= {ID_W{1'b0}};
      d_eff_r        <= 4'd1;
      cfg_expected_r <= {CNT_W{1'b0}};
    end else if (cfg_load) begin
      cfg_id_r       <= cfg_id;
      d_eff_r        <= clamp_delay(cfg_credit_delay, 4'(MAX_CD));
      cfg_expected_r <= cfg_expected;
    end else begin
      cfg_id_r       <= cfg_id_r;
      d_eff_r        <= d_eff_r;
      cfg_expected_r <= cfg_expected_r;
    end
  end

  // Per-VC reassembly FSM with flit/packet counters and sticky errors
  always_ff @(posedge clk) begin
    if (clear_s) begin
      for (int i = 0; i < MAX_VC; i++) begin
        vc_state_r[i] <= VC_IDLE;
      end
      flit_count_r <= {CNT_W{1'b0}};
      pkt_count_r  <= {CNT_W{1'b0}};
      err_r        <= 3'b000;
    end else if (flit_valid_s) begin
      flit_count_r <= sat_inc(flit_count_r);
      if (flit_dst_s != cfg_id_r) begin
        err_r[ERR_DST] <= 1'b1;
      end
      case (vc_state_r[flit_vc_s])
        VC_IDLE: begin
          if (flit_head_s && flit_tail_s) begin
            pkt_count_r <= sat_inc(pkt_count_r);
          end else if (flit_head_s) begin
            vc_state_r[flit_vc_s] <= VC_OPEN;
          end else begin
            err_r[ERR_ORPHAN] <= 1'b1;
          end
        end
        VC_OPEN: begin
          // A repeated head restarts the packet; a tail (with or without head) closes it
          if (flit_head_s) begin
            err_r[ERR_DUP_HEAD] <= 1'b1;
          end
          if (flit_tail_s) begin
            pkt_count_r           <= sat_inc(pkt_count_r);
            vc_state_r[flit_vc_s] <= VC_IDLE;
          end
        end
        default: begin
          vc_state_r[flit_vc_s] <= VC_IDLE;
        end
      endcase
    end
  end

  // Any VC with an unfinished packet blocks done
  always_comb begin
    any_open_s = 1'b0;
    for (int i = 0; i < MAX_VC; i++) begin
      any_open_s = any_open_s | (vc_state_r[i] == VC_OPEN);
    end
  end

  // done reflects the completion condition of the previous cycle's state
  always_ff @(posedge clk) begin
    if (clear_s) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (pkt_count_r == cfg_expected_r) && !any_open_s && (err_r == 3'b000);
    end
  end

  noc_eject_sink_credit_delay_line #(
    .DEPTH (MAX_CD),
    .VC_W  (VC_W),
    .TAP_W (4)
  ) u_credit_delay (
    .clk       (clk),
    .clr       (clear_s),
    .in_valid  (flit_valid_s),
    .in_vc     (flit_vc_s),
    .tap       (d_eff_r),
    .out_valid (cr_valid_s),
    .out_vc    (cr_vc_s)
  );

  assign cr_out     = {{(FLIT_W-VC_W-1){1'b0}}, cr_vc_s, cr_valid_s};
  assign flit_count = flit_count_r;
  assign pkt_count  = pkt_count_r;
  assign err        = err_r;
  assign done       = done_r;

endmodule

// File: tb/tb_noc_eject_sink.sv
// Self-checking bench for noc_eject_sink: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model (credit schedule keyed by due cycle, packet
// framing tracked as per-VC "open" flags).
module tb_noc_eject_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [3:0]  cfg_id;
  logic [3:0]  cfg_credit_delay;
  logic [15:0] cfg_expected;
  logic [11:0] in_flit;
  logic [11:0] cr_out;
  logic [15:0] flit_count;
  logic [15:0] pkt_count;
  logic [2:0]  err;
  logic        done;

  always #5 clk = ~clk;

  noc_eject_sink dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_load         (cfg_load),
    .cfg_id           (cfg_id),
    .cfg_credit_delay (cfg_credit_delay),
    .cfg_expected     (cfg_expected),
    .in_flit          (in_flit),
    .cr_out           (cr_out),
    .flit_count       (flit_count),
    .pkt_count        (pkt_count),
    .err              (err),
    .done             (done)
  );

  int passed = 0;
  int total  = 0;

  // Reference model state
  int          cyc = 0;
  logic [3:0]  m_id;
  int          m_d;
  int          m_exp;
  int          m_flits;
  int          m_pkts;
  logic [2:0]  m_err;
  logic [3:0]  m_open;
  logic        m_done;
  logic [11:0] m_cr;
  logic [11:0] sched [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [11:0] mk(input int vc, input int h, input int t, input int dst);
    logic [11:0] f;
    f = 12'h001;
    f[2:1] = 2'(vc);
    f[3]   = 1'(h);
    f[4]   = 1'(t);
    f[8:5] = 4'(dst);
    return f;
  endfunction

  task automatic model_clear();
    m_flits = 0; m_pkts = 0; m_err = 3'b000; m_open = 4'b0000;
    m_done = 1'b0; m_cr = 12'h000;
    sched.delete();
  endtask

  // Apply the specification's rules for one rising edge
  task automatic model_edge(input logic r, input logic l, input logic [11:0] f);
    int vc;
    cyc++;
    if (r) begin
      model_clear();
      m_id = 4'd0; m_d = 1; m_exp = 0;
    end else if (l) begin
      model_clear();
      m_id  = cfg_id;
      m_d   = (cfg_credit_delay == 4'd0) ? 1 : ((cfg_credit_delay > 4'd8) ? 8 : int'(cfg_credit_delay));
      m_exp = int'(cfg_expected);
    end else begin
      m_done = (m_pkts == m_exp) && (m_open == 4'b0000) && (m_err == 3'b000);
      if (sched.exists(cyc)) begin
        m_cr = sched[cyc];
        sched.delete(cyc);
      end else begin
        m_cr = 12'h000;
      end
      if (f[0]) begin
        vc = int'(f[2:1]);
        if (m_flits < 65535) m_flits++;
        sched[cyc + m_d] = {9'b0, f[2:1], 1'b1};
        if (f[8:5] != m_id) m_err[2] = 1'b1;
        if (f[3]) begin
          if (m_open[vc]) m_err[0] = 1'b1;
          if (f[4]) begin
            if (m_pkts < 65535) m_pkts++;
            m_open[vc] = 1'b0;
          end else begin
            m_open[vc] = 1'b1;
          end
        end else if (!m_open[vc]) begin
          m_err[1] = 1'b1;
        end else if (f[4]) begin
          if (m_pkts < 65535) m_pkts++;
          m_open[vc] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("cr_out", 32'(cr_out), 32'(m_cr));
    chk("flit_count", 32'(flit_count), 32'(m_flits));
    chk("pkt_count", 32'(pkt_count), 32'(m_pkts));
    chk("err", 32'(err), 32'(m_err));
    chk("done", 32'(done), 32'(m_done));
  endtask

  // One clock: drive inputs, let the edge happen, update model, check at negedge
  task automatic step(input logic r, input logic l, input logic [11:0] f);
    rst = r; cfg_load = l; in_flit = f;
    @(posedge clk);
    model_edge(r, l, f);
    @(negedge clk);
    compare_all();
  endtask

  task automatic load(input int id, input int d, input int exp);
    cfg_id = 4'(id); cfg_credit_delay = 4'(d); cfg_expected = 16'(exp);
    step(1'b0, 1'b1, 12'h000);
  endtask

  initial begin
    logic [11:0] f;
    logic [11:0] il_flits [5];
    logic [11:0] il_cr [5];
    int first_k;
    int ncr;
    int npk;
    int len;
    int vc;

    rst = 1'b1; cfg_load = 1'b0; cfg_id = 4'd0; cfg_credit_delay = 4'd0;
    cfg_expected = 16'd0; in_flit = 12'h000;

    // Reset state
    step(1'b1, 1'b0, 12'h000);
    chk("reset_cr_out", 32'(cr_out), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    step(1'b0, 1'b0, 12'h000);
    chk("idle_done_exp0", 32'(done), 32'h1);

    // Single-flit packet, d = 3
    load(5, 3, 1);
    step(1'b0, 1'b0, mk(2, 1, 1, 5));
    chk("single_flit_count", 32'(flit_count), 32'd1);
    chk("single_pkt_count", 32'(pkt_count), 32'd1);
    step(1'b0, 1'b0, 12'h000);
    chk("single_done", 32'(done), 32'h1);
    chk("single_cr_t1", 32'(cr_out), 32'h0);
    step(1'b0, 1'b0, 12'h000);
    chk("single_cr_t2", 32'(cr_out), 32'h0);
    step(1'b0, 1'b0, 12'h000);
    chk("single_cr_t3", 32'(cr_out), 32'h005);
    step(1'b0, 1'b0, 12'h000);
    chk("single_cr_t4", 32'(cr_out), 32'h0);

    // Interleaved VCs, d = 1
    load(0, 1, 2);
    il_flits[0] = mk(0, 1, 0, 0); il_flits[1] = mk(1, 1, 0, 0);
    il_flits[2] = mk(0, 0, 0, 0); il_flits[3] = mk(1, 0, 1, 0);
    il_flits[4] = mk(0, 0, 1, 0);
    il_cr[0] = 12'h001; il_cr[1] = 12'h003; il_cr[2] = 12'h001;
    il_cr[3] = 12'h003; il_cr[4] = 12'h001;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, il_flits[i]);
      if (i > 0) chk("interleave_cr", 32'(cr_out), 32'(il_cr[i-1]));
    end
    step(1'b0, 1'b0, 12'h000);
    chk("interleave_cr_last", 32'(cr_out), 32'(il_cr[4]));
    chk("interleave_pkts", 32'(pkt_count), 32'd2);
    chk("interleave_flits", 32'(flit_count), 32'd5);
    chk("interleave_err", 32'(err), 32'h0);

    // Ordering errors on vc3
    load(0, 2, 1);
    step(1'b0, 1'b0, mk(3, 0, 0, 0));
    chk("orphan_err", 32'(err), 32'h2);
    step(1'b0, 1'b0, mk(3, 1, 0, 0));
    step(1'b0, 1'b0, mk(3, 1, 0, 0));
    chk("orphan_credit", 32'(cr_out), 32'h007);
    chk("dup_head_err", 32'(err), 32'h3);
    step(1'b0, 1'b0, mk(3, 0, 1, 0));
    chk("err_tail_pkts", 32'(pkt_count), 32'd1);
    repeat (3) step(1'b0, 1'b0, 12'h000);
    chk("err_done_low", 32'(done), 32'h0);

    // Wrong destination
    load(4, 1, 1);
    step(1'b0, 1'b0, mk(0, 1, 1, 7));
    chk("dst_err", 32'(err), 32'h4);
    chk("dst_flits", 32'(flit_count), 32'd1);
    step(1'b0, 1'b0, 12'h000);

    // Delay 0 behaves as 1
    load(0, 0, 1);
    step(1'b0, 1'b0, mk(1, 1, 1, 0));
    step(1'b0, 1'b0, 12'h000);
    chk("d0_credit", 32'(cr_out), 32'h003);

    // Delay 15 saturates at 8, then back-to-back flits all credited
    load(0, 15, 8);
    step(1'b0, 1'b0, mk(2, 1, 1, 0));
    first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 12'h000);
      if (cr_out[0] && first_k == 0) first_k = k;
    end
    chk("d15_latency", 32'(first_k), 32'd8);
    ncr = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, (k < 8) ? mk(k % 4, 1, 1, 0) : 12'h000);
      if (cr_out[0]) ncr++;
    end
    chk("b2b_credits", 32'(ncr), 32'd8);

    // Reset mid-packet with credits in flight
    load(0, 5, 0);
    step(1'b0, 1'b0, mk(1, 1, 0, 0));
    step(1'b0, 1'b0, mk(1, 0, 0, 0));
    step(1'b0, 1'b0, mk(0, 1, 1, 0));
    step(1'b1, 1'b0, 12'h000);
    chk("rst_flits", 32'(flit_count), 32'd0);
    ncr = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 12'h000);
      if (cr_out != 12'h000) ncr++;
    end
    chk("rst_no_credits", 32'(ncr), 32'd0);
    step(1'b0, 1'b0, mk(1, 0, 1, 0));
    chk("rst_tail_orphan", 32'(err), 32'h2);

    // Well-formed random packets: should finish with done = 1
    npk = 12;
    load(9, $urandom_range(0, 15), npk);
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(1, 4);
      vc  = $urandom_range(0, 3);
      for (int j = 0; j < len; j++) begin
        step(1'b0, 1'b0, mk(vc, (j == 0) ? 1 : 0, (j == len - 1) ? 1 : 0, 9));
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 12'(($urandom & 32'hFFE)));
      end
    end
    repeat (10) step(1'b0, 1'b0, 12'h000);
    chk("wellformed_done", 32'(done), 32'h1);
    chk("wellformed_pkts", 32'(pkt_count), 32'(npk));

    // Unconstrained random traffic with occasional resets
    for (int r = 0; r < 6; r++) begin
      load($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 20));
      for (int c = 0; c < 150; c++) begin
        f = 12'($urandom);
        f[0] = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 9) < 8) f[8:5] = cfg_id;
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1'b0, f);
      end
      repeat (10) step(1'b0, 1'b0, 12'h000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
